seg14_scan_ctrl: RTL and testbench
==================================

SEG14_SCAN_CTRL -- requirements
Module: seg14_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL, default 4, meaning clock cycles each digit is driven (legal 1..255).
REQ-002 SHALL have parameter SCROLL_DIV, default 64, meaning full frames per scroll step (legal 1..255).
REQ-003 SHALL have clk  input  1  the single clock; all state changes on posedge clk.
REQ-004 SHALL have rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have enable  input  1  scan enable; low blanks the display.
REQ-006 SHALL have wr_en  input  1  character write request.
REQ-007 SHALL have wr_addr  input  4  message-buffer slot 0..15.
REQ-008 SHALL have wr_char  input  6  character code.
REQ-009 SHALL have wr_ready  output  1  high when a write is accepted this cycle.
REQ-010 SHALL have sel  output  12  one-hot digit select; bit 0 is digit 0.
REQ-011 SHALL have segm  output  14  segment pattern for the selected digit.
REQ-012 SHALL have frame_tick  output  1  one-cycle pulse at the end of each 12-digit frame.

Function
REQ-013 SHALL hold a 16-entry x 6-bit shadow buffer (write side) and a 16-entry active buffer (display side).
REQ-014 SHALL map codes: 0 space, 1..26 A..Z, 27..36 digits 0..9; codes 37..63 display as space (all zero).
REQ-015 SHALL run FSM IDLE, SHOW, BLANK; all outputs registered.
REQ-016 IDLE: sel=0, segm=0; with enable=1, next state SHOW, digit index 0.
REQ-017 SHOW: sel=one-hot(digit), segm=font(active[(base+digit) mod 16]) for exactly DWELL cycles, then BLANK.
REQ-018 BLANK: sel=0, segm=0 for exactly one cycle; digit increments, wrapping 11 -> 0; then SHOW.
REQ-019 On BLANK after digit 11: frame_tick=1 that cycle; frame counter increments.
REQ-020 When frame counter reaches SCROLL_DIV: counter clears, base <= (base+1) mod 16 at the same edge.
REQ-021 Write accepted when wr_en=1 and wr_ready=1: shadow[wr_addr] <= wr_char, dirty flag set.
REQ-022 In the frame-end BLANK cycle with dirty=1: active <= shadow, dirty cleared, wr_ready=0 that cycle.
REQ-023 wr_ready SHALL be 1 in all other cycles; a write presented while wr_ready=0 is dropped.
REQ-024 enable falling SHALL force IDLE at the next edge (sel=0, segm=0); digit and frame counter clear; base and buffers retained.
REQ-025 frame_tick SHALL never assert in IDLE.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, sel=0, segm=0, frame_tick=0, wr_ready=1, digit=0, base=0, frame counter=0, dirty=0, both buffers all 0.
REQ-027 Reset mid-frame SHALL abandon the frame; no commit or scroll occurs.

Configuration
REQ-028 Macro SEG14_SCROLL_EN defined: scrolling per REQ-020.
REQ-029 SEG14_SCROLL_EN undefined: base fixed at 0, slots 12..15 never displayed, frame_tick and commit behaviour unchanged.

Structure
REQ-030 Shared package seg14_pkg SHALL hold the character-code constants, the 38-entry 14-bit font table, and the FSM state enum.
REQ-031 Font lookup SHALL be sub-module seg14_font (combinational, 6-bit code in, 14-bit pattern out).
REQ-032 Font entries SHALL include A=14'b11101111000000, D=14'b11110000010010, N=14'b01101100100100.

Verification (DWELL=4, SCROLL_DIV=2)
REQ-033 Reset, enable=1: first edge sel=12'h001, segm=0; sel=12'h001 for 4 cycles, then 0 for 1 cycle, then 12'h002; frame_tick every 60 cycles.
REQ-034 Write codes 14,1,4,1 (N,A,D,A) to slots 3..6 mid-frame: digits unchanged until frame-end commit; next frame digit 4 shows 14'b11101111000000, digit 3 shows 14'b01101100100100.
REQ-035 wr_en held high across frame-end commit with dirty=1: wr_ready=0 that one cycle, that write dropped, writes before and after take effect.
REQ-036 With SEG14_SCROLL_EN, after 2 frames digit 3 shows slot 4 (A); after 32 frames base wraps to 0; without the macro digit 3 still shows N.
REQ-037 Code 40 written: digit shows segm=0; enable dropped mid-SHOW: sel=0 next edge, re-enable restarts at digit 0 with base unchanged.
REQ-038 rst_n asserted mid-SHOW, asynchronous to clk: sel and segm 0 before next edge; buffers cleared.

Source files
------------

// File: rtl/seg14_pkg.sv
// Shared constants for the 14-segment scan controller: character codes, font table, FSM states.
// Scrolling is built only when SEG14_SCROLL_EN is defined.
package seg14_pkg;

    localparam int unsigned NumDigits = 12;
    localparam int unsigned NumSlots  = 16;
    localparam int unsigned NumGlyphs = 38;

    localparam logic [5:0] CodeDigit0 = 6'd27;
    localparam logic [5:0] CodeDigit9 = CodeDigit0 + 6'd9;
    localparam logic [5:0] CodeBlank  = 6'd37;
    localparam logic [3:0] LastDigit  = 4'(NumDigits - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShow,
        StBlank
    } scan_state_e;

    // Bit order MSB..LSB: a b c d e f g1 g2 h i j k l m
    localparam logic [13:0] FontTable [NumGlyphs] = '{
        14'b00000000000000,  // space
        14'b11101111000000,  // A
        14'b11110001010010,  // B
        14'b10011100000000,  // C
        14'b11110000010010,  // D
        14'b10011110000000,  // E
        14'b10001110000000,  // F
        14'b10111101000000,  // G
        14'b01101111000000,  // H
        14'b10010000010010,  // I
        14'b01111000000000,  // J
        14'b00001110001100,  // K
        14'b00011100000000,  // L
        14'b01101100101000,  // M
        14'b01101100100100,  // N
        14'b11111100000000,  // O
        14'b11001111000000,  // P
        14'b11111100000100,  // Q
        14'b11001111000100,  // R
        14'b10110111000000,  // S
        14'b10000000010010,  // T
        14'b01111100000000,  // U
        14'b00001100001001,  // V
        14'b01101100000101,  // W
        14'b00000000101101,  // X
        14'b00000000101010,  // Y
        14'b10010000001001,  // Z
        14'b11111100001001,  // 0
        14'b01100000001000,  // 1
        14'b11011011000000,  // 2
        14'b11110011000000,  // 3
        14'b01100111000000,  // 4
        14'b10110111000000,  // 5
        14'b10111111000000,  // 6
        14'b11100000000000,  // 7
        14'b11111111000000,  // 8
        14'b11110111000000,  // 9
        14'b00000000000000   // undefined codes
    };

endpackage

// File: rtl/seg14_font.sv
// Combinational font lookup: 6-bit character code to 14-segment pattern.
module seg14_font
    import seg14_pkg::*;
(
    input  logic [5:0]  code,
    output logic [13:0] pattern
);

    always_comb begin
        if (code > CodeDigit9) begin
            pattern = FontTable[CodeBlank];
        end else begin
            pattern = FontTable[code];
        end
    end

endmodule

// File: rtl/seg14_scan_ctrl.sv
// Multiplexed 12-digit 14-segment display scanner with double-buffered 16-slot message.
// Define SEG14_SCROLL_EN to advance the message window every SCROLL_DIV frames.
module seg14_scan_ctrl
    import seg14_pkg::*;
#(
    parameter int unsigned DWELL      = 4,
    parameter int unsigned SCROLL_DIV = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 wr_en,
    input  logic [3:0]           wr_addr,
    input  logic [5:0]           wr_char,
    output logic                 wr_ready,
    output logic [NumDigits-1:0] sel,
    output logic [13:0]          segm,
    output logic                 frame_tick
);

    scan_state_e state_q, state_d;
    logic [3:0]  digit_q, digit_d;
    logic [7:0]  dwell_q, dwell_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [3:0]  base_q, base_d;
    logic        dirty_q, dirty_d;

    logic [5:0]  shadow_q [NumSlots];
    logic [5:0]  active_q [NumSlots];

    logic [NumDigits-1:0] sel_q, sel_d;
    logic [13:0]          segm_q, segm_d;
    logic                 frame_tick_q, frame_tick_d;
    logic                 wr_ready_q, wr_ready_d;

    logic        wr_accept;
    logic        frame_end;
    logic        commit;
    logic [3:0]  slot_idx;
    logic [5:0]  show_code;
    logic [13:0] font_pat;

    assign wr_accept = wr_en & wr_ready_q;
    assign frame_end = (state_q == StBlank) && (digit_q == LastDigit);
    assign commit    = frame_end & dirty_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            digit_q     <= '0;
            dwell_q     <= '0;
            frame_cnt_q <= '0;
            base_q      <= '0;
            dirty_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_q     <= digit_d;
            dwell_q     <= dwell_d;
            frame_cnt_q <= frame_cnt_d;
            base_q      <= base_d;
            dirty_q     <= dirty_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        digit_d     = digit_q;
        dwell_d     = dwell_q;
        frame_cnt_d = frame_cnt_q;
        base_d      = base_q;
        if (!enable) begin
            state_d     = StIdle;
            digit_d     = '0;
            dwell_d     = '0;
            frame_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StShow;
                    digit_d = '0;
                    dwell_d = '0;
                end
                StShow: begin
                    if (dwell_q == 8'(DWELL - 1)) begin
                        state_d = StBlank;
                        dwell_d = '0;
                    end else begin
                        dwell_d = dwell_q + 8'd1;
                    end
                end
                StBlank: begin
                    state_d = StShow;
                    if (digit_q == LastDigit) begin
                        digit_d = '0;
                        if (frame_cnt_q == 8'(SCROLL_DIV - 1)) begin
                            frame_cnt_d = '0;
`ifdef SEG14_SCROLL_EN
                            base_d      = base_q + 4'd1;
`endif
                        end else begin
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end
                    end else begin
                        digit_d = digit_q + 4'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        dirty_d = dirty_q;
        if (commit) begin
            dirty_d = 1'b0;
        end
        if (wr_accept) begin
            dirty_d = 1'b1;
        end
    end

    // Outputs are registered from the state being entered, so the code shown must
    // see a commit happening on the same edge.
    assign slot_idx  = base_d + digit_d;
    assign show_code = commit ? shadow_q[slot_idx] : active_q[slot_idx];

    seg14_font u_font (
        .code    (show_code),
        .pattern (font_pat)
    );

    // Output logic
    always_comb begin
        sel_d        = '0;
        segm_d       = '0;
        frame_tick_d = (state_d == StBlank) && (digit_d == LastDigit);
        wr_ready_d   = !(frame_tick_d && dirty_d);
        if (state_d == StShow) begin
            sel_d  = NumDigits'(1) << digit_d;
            segm_d = font_pat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q        <= '0;
            segm_q       <= '0;
            frame_tick_q <= 1'b0;
            wr_ready_q   <= 1'b1;
        end else begin
            sel_q        <= sel_d;
            segm_q       <= segm_d;
            frame_tick_q <= frame_tick_d;
            wr_ready_q   <= wr_ready_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumSlots; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (commit) begin
                for (int i = 0; i < NumSlots; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            if (wr_accept) begin
                shadow_q[wr_addr] <= wr_char;
            end
        end
    end

    assign sel        = sel_q;
    assign segm       = segm_q;
    assign frame_tick = frame_tick_q;
    assign wr_ready   = wr_ready_q;

endmodule

// File: tb/tb_seg14_scan_ctrl.sv
// Randomized scoreboard bench for seg14_scan_ctrl against a frame-position reference model.
module tb_seg14_scan_ctrl;

    localparam int Dwell     = 4;
    localparam int ScrollDiv = 2;
    localparam int Slot      = Dwell + 1;
    localparam int Frame     = 12 * Slot;
`ifdef SEG14_SCROLL_EN
    localparam bit ScrollEn = 1'b1;
`else
    localparam bit ScrollEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [5:0]  wr_char = '0;
    logic        wr_ready;
    logic [11:0] sel;
    logic [13:0] segm;
    logic        frame_tick;

    always #5 clk = ~clk;

    seg14_scan_ctrl #(
        .DWELL      (Dwell),
        .SCROLL_DIV (ScrollDiv)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_char    (wr_char),
        .wr_ready   (wr_ready),
        .sel        (sel),
        .segm       (segm),
        .frame_tick (frame_tick)
    );

    typedef struct packed {
        logic [11:0] sel;
        logic [13:0] segm;
        logic        tick;
        logic        ready;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Glyphs for codes 0..36: space, A..Z, 0..9
    bit [13:0] font_tab [37] = '{
        14'b00000000000000, 14'b11101111000000, 14'b11110001010010, 14'b10011100000000,
        14'b11110000010010, 14'b10011110000000, 14'b10001110000000, 14'b10111101000000,
        14'b01101111000000, 14'b10010000010010, 14'b01111000000000, 14'b00001110001100,
        14'b00011100000000, 14'b01101100101000, 14'b01101100100100, 14'b11111100000000,
        14'b11001111000000, 14'b11111100000100, 14'b11001111000100, 14'b10110111000000,
        14'b10000000010010, 14'b01111100000000, 14'b00001100001001, 14'b01101100000101,
        14'b00000000101101, 14'b00000000101010, 14'b10010000001001, 14'b11111100001001,
        14'b01100000001000, 14'b11011011000000, 14'b11110011000000, 14'b01100111000000,
        14'b10110111000000, 14'b10111111000000, 14'b11100000000000, 14'b11111111000000,
        14'b11110111000000
    };

    // Reference model: position within a 60-cycle frame rather than an FSM
    bit       m_run;
    int       m_pos, m_fcnt, m_base;
    bit       m_dirty, m_ready;
    bit [5:0] m_shadow [16];
    bit [5:0] m_active [16];

    function automatic bit [13:0] glyph(input bit [5:0] c);
        return (c < 6'd37) ? font_tab[c] : 14'd0;
    endfunction

    function automatic void model_reset();
        m_run = 0; m_pos = 0; m_fcnt = 0; m_base = 0; m_dirty = 0; m_ready = 1;
        for (int i = 0; i < 16; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
    endfunction

    function automatic void model_edge();
        bit accept, fend;
        accept = wr_en && m_ready;
        fend   = m_run && (m_pos == Frame - 1);
        if (fend && m_dirty) begin
            m_active = m_shadow;
            m_dirty  = 0;
        end
        if (accept) begin
            m_shadow[wr_addr] = wr_char;
            m_dirty = 1;
        end
        if (!enable) begin
            m_run = 0; m_pos = 0; m_fcnt = 0;
        end else if (!m_run) begin
            m_run = 1; m_pos = 0;
        end else if (fend) begin
            m_pos = 0;
            m_fcnt++;
            if (m_fcnt == ScrollDiv) begin
                m_fcnt = 0;
                if (ScrollEn) m_base = (m_base + 1) % 16;
            end
        end else begin
            m_pos++;
        end
    endfunction

    function automatic bit model_showing();
        return m_run && ((m_pos % Slot) < Dwell);
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   digit;
        e = '0;
        digit = m_pos / Slot;
        if (model_showing()) begin
            e.sel  = 12'(1 << digit);
            e.segm = glyph(m_active[(m_base + digit) % 16]);
        end
        e.tick  = m_run && (m_pos == Frame - 1);
        e.ready = !(e.tick && m_dirty);
        return e;
    endfunction

    task automatic step();
        exp_t e;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        e = model_out();
        m_ready = e.ready;
        sb_q.push_back(e);
        #1;
    endtask

    task automatic rand_inputs(input int wr_pct);
        wr_en   = ($urandom_range(0, 99) < wr_pct);
        wr_addr = 4'($urandom_range(0, 15));
        wr_char = 6'($urandom_range(0, 63));
    endtask

    // Monitor: one output sample per cycle, compared against the oldest expectation
    initial begin
        exp_t e, g;
        forever begin
            @(negedge clk);
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL scoreboard_empty at %0t: DUT output present, no expected entry", $time);
            end else begin
                e = sb_q.pop_front();
                g = {sel, segm, frame_tick, wr_ready};
                if (g === e) n_pass++;
                else $display("FAIL outputs at %0t: got sel=%h segm=%b tick=%b ready=%b, required sel=%h segm=%b tick=%b ready=%b",
                              $time, g.sel, g.segm, g.tick, g.ready, e.sel, e.segm, e.tick, e.ready);
            end
        end
    end

    initial begin
        int en_off;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) step();
        #2 rst_n = 1'b1;
        enable = 1'b1;

        // Mid-frame write of N,A,D,A into slots 3..6, then let it commit and display
        repeat (20) step();
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(3 + i);
            wr_char = (i == 0) ? 6'd14 : (i == 2) ? 6'd4 : 6'd1;
            step();
        end
        wr_en = 1'b0;
        repeat (3 * Frame) step();

        // wr_en held across frame-end commits
        for (int i = 0; i < 2 * Frame + 10; i++) begin
            rand_inputs(100);
            step();
        end
        wr_en = 1'b0;

        // Enable dropped mid-SHOW, then restored
        for (int k = 0; k < 10 && !model_showing(); k++) step();
        enable = 1'b0;
        repeat (3) step();
        enable = 1'b1;
        repeat (Frame) step();

        // Long random run: writes, occasional enable drops, scroll wrap when enabled
        en_off = 0;
        for (int i = 0; i < 40 * Frame; i++) begin
            if (en_off > 0) en_off--;
            else if ($urandom_range(0, 299) == 0) en_off = $urandom_range(1, 6);
            enable = (en_off == 0);
            rand_inputs(15);
            step();
        end
        enable = 1'b1;
        wr_en  = 1'b0;
        repeat (5) step();

        // Asynchronous reset mid-SHOW
        for (int k = 0; k < 10 && !model_showing(); k++) step();
        #2;
        sb_q.delete();
        model_reset();
        sb_q.push_back(model_out());
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (sel == 12'h000 && segm == 14'h0000 && frame_tick == 1'b0 && wr_ready == 1'b1) n_pass++;
        else $display("FAIL async_reset: got sel=%h segm=%b tick=%b ready=%b, required sel=000 segm=0 tick=0 ready=1",
                      sel, segm, frame_tick, wr_ready);
        repeat (2) step();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 2 * Frame; i++) begin
            rand_inputs(5);
            step();
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
